// File: rtl/control_types_pkg.sv
// Shared control-path types for the pipeline sequencer.
// Provides hz_state_t, the stage control bundle and register index width.
package control_types_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_DRAIN,
    S_HALTED
  } hz_state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_ctl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: EX load whose rd feeds a source of the ID instruction.
// Ports: rs1/rs2 index+use of ID, rd index and load flag of EX -> load_use.
module load_use_detect
  import control_types_pkg::*;
(
  input  logic [REG_IDX_W-1:0] r1_reg_idx_id,
  input  logic [REG_IDX_W-1:0] r2_reg_idx_id,
  input  logic                 r1_used_id,
  input  logic                 r2_used_id,
  input  logic [REG_IDX_W-1:0] wr_reg_idx_ex,
  input  logic                 mem_do_read_ctrl_ex,
  output logic                 load_use
);

  logic rd_live;
  logic hit1;
  logic hit2;

  always_comb begin
    rd_live  = mem_do_read_ctrl_ex
             & (wr_reg_idx_ex != '0);
    hit1     = r1_used_id
             & (r1_reg_idx_id == wr_reg_idx_ex);
    hit2     = r2_used_id
             & (r2_reg_idx_id == wr_reg_idx_ex);
    load_use = rd_live & (hit1 | hit2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/clears, halt/drain FSM, dmem watchdog.
// Ports: hazard inputs, halt/resume, stage en/clear, halted, timeout flag,
// stall_cnt/flush_cnt (built only with HAZARD_PERF_CNT_EN, else tied to 0).
module pipeline_hazard_ctrl
  import control_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       r1_reg_idx_id,
  input  logic [4:0]       r2_reg_idx_id,
  input  logic             r1_used_id,
  input  logic             r2_used_id,
  input  logic [4:0]       wr_reg_idx_ex,
  input  logic             mem_do_read_ctrl_ex,
  input  logic             ex_redirect,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             mem_wb_clear,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DC_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WC_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [DC_W-1:0] DRAIN_INIT =
    DC_W'(DRAIN_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_MAX =
    WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_ERR =
    WC_W'(MEM_TIMEOUT - 1);
  localparam logic WDOG_ON = (MEM_TIMEOUT != 0);

  hz_state_t       state;
  hz_state_t       state_nxt;
  logic [DC_W-1:0] drain_cnt;
  logic [DC_W-1:0] drain_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            err_q;

  logic lu_raw;
  logic lu_q;
  logic active;
  logic freeze;
  logic redir;
  logic lu_eff;
  logic advance;

  stage_ctl_t en;
  stage_ctl_t clr;

  load_use_detect u_lud (
    .r1_reg_idx_id       (r1_reg_idx_id),
    .r2_reg_idx_id       (r2_reg_idx_id),
    .r1_used_id          (r1_used_id),
    .r2_used_id          (r2_used_id),
    .wr_reg_idx_ex       (wr_reg_idx_ex),
    .mem_do_read_ctrl_ex (mem_do_read_ctrl_ex),
    .load_use            (lu_raw)
  );

  // lu_q: the stall cycle already inserted the bubble, so a
  // load_use seen again right after it is stale and ignored.
  always_comb begin
    active  = (state != S_HALTED);
    freeze  = active & dmem_req_mem & ~dmem_ready;
    redir   = active & ex_redirect & ~freeze;
    lu_eff  = active & lu_raw & ~freeze
            & ~redir & ~lu_q;
    advance = ~freeze & ~lu_eff;
  end

  always_comb begin
    en  = '1;
    clr = '0;
    if (!rst_n) begin
      en  = '0;
      clr = '1;
    end else if (state == S_HALTED) begin
      en.pc     = 1'b0;
      en.if_id  = 1'b0;
      en.id_ex  = 1'b0;
      en.ex_mem = 1'b0;
      clr.mem_wb = 1'b1;
    end else begin
      unique case (1'b1)
        freeze: begin
          en.pc      = 1'b0;
          en.if_id   = 1'b0;
          en.id_ex   = 1'b0;
          en.ex_mem  = 1'b0;
          clr.mem_wb = 1'b1;
        end
        redir: begin
          clr.if_id = 1'b1;
          clr.id_ex = 1'b1;
        end
        lu_eff: begin
          en.pc     = 1'b0;
          en.if_id  = 1'b0;
          clr.id_ex = 1'b1;
        end
        default: ;
      endcase
      // Draining: no new fetch. A held IF/ID (stall or
      // freeze) keeps its instruction; a redirect still
      // loads the PC so resume starts at the target.
      if (state == S_DRAIN) begin
        en.pc = redir;
        if (en.if_id) clr.if_id = 1'b1;
      end
    end
  end

  always_comb begin
    pc_en        = en.pc;
    if_id_en     = en.if_id;
    id_ex_en     = en.id_ex;
    ex_mem_en    = en.ex_mem;
    mem_wb_en    = en.mem_wb;
    if_id_clear  = clr.if_id;
    id_ex_clear  = clr.id_ex;
    ex_mem_clear = clr.ex_mem;
    mem_wb_clear = clr.mem_wb;
    halted       = (state == S_HALTED);
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    unique case (state)
      S_RUN: begin
        if (freeze) begin
          state_nxt = S_MEM_WAIT;
        end else if (halt_req) begin
          state_nxt = S_DRAIN;
          drain_nxt = DRAIN_INIT;
        end
      end
      S_MEM_WAIT: begin
        if (!freeze) begin
          if (halt_req) begin
            state_nxt = S_DRAIN;
            drain_nxt = DRAIN_INIT;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (advance) begin
          if (drain_cnt == '0) begin
            state_nxt = S_HALTED;
          end else begin
            drain_nxt = drain_cnt - DC_W'(1);
          end
        end
      end
      S_HALTED: begin
        if (resume_req) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      lu_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      lu_q      <= lu_eff;
    end
  end

  // Counts consecutive frozen cycles in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (freeze) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + WC_W'(1);
        end
        if (WDOG_ON && wait_cnt == WAIT_ERR) begin
          err_q <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (freeze | lu_eff) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (redir) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios
// plus randomized cycles against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 32;
  localparam int DC = 4;
  localparam int TA = 255;
  localparam int TB = 2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [9:0] V_NORM  = 10'b11111_0000_0;
  localparam logic [9:0] V_RST   = 10'b00000_1111_0;
  localparam logic [9:0] V_FRZ   = 10'b00001_0001_0;
  localparam logic [9:0] V_RDR   = 10'b11111_1100_0;
  localparam logic [9:0] V_LU    = 10'b00111_0100_0;
  localparam logic [9:0] V_HALT  = 10'b00001_0001_1;
  localparam logic [9:0] V_DRAIN = 10'b01111_1000_0;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] r1, r2, wr;
  logic u1, u2, ld, exr, dreq, drdy, hreq, rreq;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_clear, id_ex_clear, ex_mem_clear;
  logic mem_wb_clear, halted, err_a;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic [9:0] b_ctl;
  logic b_halted, err_b;
  logic [CW-1:0] b_stall, b_flush;

  wire [9:0] outv = {pc_en, if_id_en, id_ex_en,
    ex_mem_en, mem_wb_en, if_id_clear, id_ex_clear,
    ex_mem_clear, mem_wb_clear, halted};

  int n_chk = 0;
  int n_fail = 0;

  int m_st;
  int m_left;
  int m_run;
  bit m_err_a, m_err_b, m_prev_lu;
  bit frz, rdr, lu;
  logic [CW-1:0] m_stall, m_flush;
  logic [9:0] m_exp;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(DC), .MEM_TIMEOUT(TA), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r1_reg_idx_id(r1), .r2_reg_idx_id(r2),
    .r1_used_id(u1), .r2_used_id(u2),
    .wr_reg_idx_ex(wr), .mem_do_read_ctrl_ex(ld),
    .ex_redirect(exr), .dmem_req_mem(dreq),
    .dmem_ready(drdy), .halt_req(hreq),
    .resume_req(rreq),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_clear(if_id_clear),
    .id_ex_clear(id_ex_clear),
    .ex_mem_clear(ex_mem_clear),
    .mem_wb_clear(mem_wb_clear), .halted(halted),
    .mem_timeout_err(err_a),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(DC), .MEM_TIMEOUT(TB), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .r1_reg_idx_id(r1), .r2_reg_idx_id(r2),
    .r1_used_id(u1), .r2_used_id(u2),
    .wr_reg_idx_ex(wr), .mem_do_read_ctrl_ex(ld),
    .ex_redirect(exr), .dmem_req_mem(dreq),
    .dmem_ready(drdy), .halt_req(hreq),
    .resume_req(rreq),
    .pc_en(b_ctl[9]), .if_id_en(b_ctl[8]),
    .id_ex_en(b_ctl[7]), .ex_mem_en(b_ctl[6]),
    .mem_wb_en(b_ctl[5]), .if_id_clear(b_ctl[4]),
    .id_ex_clear(b_ctl[3]),
    .ex_mem_clear(b_ctl[2]),
    .mem_wb_clear(b_ctl[1]), .halted(b_halted),
    .mem_timeout_err(err_b),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  assign b_ctl[0] = b_halted;

  task automatic idle_inputs();
    r1 = 0; r2 = 0; wr = 0; u1 = 0; u2 = 0; ld = 0;
    exr = 0; dreq = 0; drdy = 0; hreq = 0; rreq = 0;
  endtask

  task automatic set_lu();
    ld = 1; wr = 5; r1 = 5; u1 = 1; r2 = 3; u2 = 1;
  endtask

  task automatic model_reset();
    m_st = 0; m_left = 0; m_run = 0;
    m_err_a = 0; m_err_b = 0; m_prev_lu = 0;
    m_stall = '0; m_flush = '0;
  endtask

  // Expected controls for the current inputs and mode.
  task automatic model_eval();
    bit raw;
    raw = ld && wr != 0 &&
      ((u1 && r1 == wr) || (u2 && r2 == wr));
    if (m_st == 3) begin
      frz = 0; rdr = 0; lu = 0;
      m_exp = V_HALT;
    end else begin
      frz = dreq && !drdy;
      rdr = !frz && exr;
      lu  = !frz && !rdr && raw && !m_prev_lu;
      m_exp = frz ? V_FRZ : rdr ? V_RDR :
              lu ? V_LU : V_NORM;
      if (m_st == 2) begin
        m_exp[9] = rdr;
        if (m_exp[8]) m_exp[4] = 1'b1;
      end
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_commit();
    model_eval();
    if (frz) m_run++;
    else m_run = 0;
    if (m_run >= TA) m_err_a = 1;
    if (m_run >= TB) m_err_b = 1;
    m_prev_lu = lu;
    if (frz || lu) m_stall++;
    if (rdr) m_flush++;
    case (m_st)
      0: if (frz) m_st = 1;
         else if (hreq) begin m_st = 2; m_left = DC; end
      1: if (!frz) begin
           if (hreq) begin m_st = 2; m_left = DC; end
           else m_st = 0;
         end
      2: if (!frz && !lu) begin
           m_left--;
           if (m_left == 0) m_st = 3;
         end
      3: if (rreq) m_st = 0;
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    model_commit();
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (outv !== V_RST) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", outv, V_RST);
    end
    n_chk++;
    if ({err_a, err_b, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: err %b%b st %0d fl %0d want 0",
        err_a, err_b, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #2;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL after_reset: got %b want %b", outv, V_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_lu(); u2 = 0;
    #0;
    n_chk++;
    if (outv !== V_LU) begin
      n_fail++;
      $display("FAIL load_use: got %b want %b", outv, V_LU);
    end
    tick();
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL lu_one_cycle: got %b want %b", outv, V_NORM);
    end
    idle_inputs();
    tick();
    n_chk++;
    if (stall_cnt !== (PERF ? CW'(1) : CW'(0))) begin
      n_fail++;
      $display("FAIL lu_stall_cnt: got %0d want %0d",
        stall_cnt, PERF ? 1 : 0);
    end
  endtask

  task automatic test_no_stall();
    ld = 1; wr = 0; r1 = 0; u1 = 1;
    #0;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL lu_x0: got %b want %b", outv, V_NORM);
    end
    tick();
    wr = 5; r1 = 5; u1 = 0; r2 = 7; u2 = 1;
    #0;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL lu_unused: got %b want %b", outv, V_NORM);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_redirect_lu();
    set_lu(); exr = 1;
    #0;
    n_chk++;
    if (outv !== V_RDR) begin
      n_fail++;
      $display("FAIL redir_lu: got %b want %b", outv, V_RDR);
    end
    idle_inputs();
    tick();
    n_chk++;
    if (flush_cnt !== (PERF ? CW'(1) : CW'(0)) ||
        stall_cnt !== (PERF ? CW'(1) : CW'(0))) begin
      n_fail++;
      $display("FAIL redir_cnt: fl %0d st %0d want %0d %0d",
        flush_cnt, stall_cnt, PERF ? 1 : 0, PERF ? 1 : 0);
    end
  endtask

  task automatic test_mem_freeze();
    dreq = 1; drdy = 0;
    for (int i = 0; i < 3; i++) begin
      #0;
      n_chk++;
      if (outv !== V_FRZ) begin
        n_fail++;
        $display("FAIL freeze_%0d: got %b want %b", i, outv, V_FRZ);
      end
      tick();
      if (i == 1) begin
        n_chk++;
        if (err_b !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_set: got %b want 1", err_b);
        end
      end
    end
    drdy = 1;
    #0;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL freeze_ready: got %b want %b", outv, V_NORM);
    end
    idle_inputs();
    tick();
    tick();
    n_chk++;
    if (err_b !== 1'b1 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_sticky: got a=%b b=%b want a=0 b=1",
        err_a, err_b);
    end
    n_chk++;
    if (stall_cnt !== (PERF ? CW'(4) : CW'(0))) begin
      n_fail++;
      $display("FAIL freeze_stall_cnt: got %0d want %0d",
        stall_cnt, PERF ? 4 : 0);
    end
  endtask

  task automatic test_halt_drain();
    logic [9:0] want;
    hreq = 1;
    #0;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL halt_req_cyc: got %b want %b", outv, V_NORM);
    end
    tick();
    hreq = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) set_lu();
      else idle_inputs();
      want = (i == 1) ? V_LU : V_DRAIN;
      #0;
      n_chk++;
      if (outv !== want) begin
        n_fail++;
        $display("FAIL drain_%0d: got %b want %b", i, outv, want);
      end
      tick();
    end
    idle_inputs();
    hreq = 1; set_lu(); exr = 1;
    for (int i = 0; i < 2; i++) begin
      #0;
      n_chk++;
      if (outv !== V_HALT) begin
        n_fail++;
        $display("FAIL halted_%0d: got %b want %b", i, outv, V_HALT);
      end
      tick();
    end
    idle_inputs();
    rreq = 1;
    #0;
    n_chk++;
    if (outv !== V_HALT) begin
      n_fail++;
      $display("FAIL resume_cyc: got %b want %b", outv, V_HALT);
    end
    tick();
    rreq = 0;
    #0;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL resumed: got %b want %b", outv, V_NORM);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    dreq = 1; drdy = 0;
    tick();
    rst_n = 0;
    #1;
    n_chk++;
    if (outv !== V_RST || b_ctl !== V_RST) begin
      n_fail++;
      $display("FAIL async_reset: got %b/%b want %b",
        outv, b_ctl, V_RST);
    end
    n_chk++;
    if (err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", err_b);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #2;
    n_chk++;
    if (outv !== V_FRZ) begin
      n_fail++;
      $display("FAIL post_rst_frz: got %b want %b", outv, V_FRZ);
    end
    tick();
    drdy = 1;
    #0;
    n_chk++;
    if (outv !== V_NORM) begin
      n_fail++;
      $display("FAIL post_rst_rdy: got %b want %b", outv, V_NORM);
    end
    idle_inputs();
    tick();
    n_chk++;
    if (err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_cnt_clr: err got %b want 0", err_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      wr = 5'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      exr  = ($urandom_range(0, 99) < 15);
      dreq = ($urandom_range(0, 99) < 30);
      drdy = 1'($urandom_range(0, 1));
      hreq = ($urandom_range(0, 99) < 6);
      rreq = ($urandom_range(0, 99) < 20);
      #0;
      model_eval();
      n_chk++;
      if (outv !== m_exp) begin
        n_fail++;
        $display("FAIL rand_ctl c%0d: got %b want %b",
          c, outv, m_exp);
      end
      n_chk++;
      if (err_a !== m_err_a || err_b !== m_err_b) begin
        n_fail++;
        $display("FAIL rand_err c%0d: got %b%b want %b%b",
          c, err_a, err_b, m_err_a, m_err_b);
      end
      n_chk++;
      if (stall_cnt !== (PERF ? m_stall : '0) ||
          flush_cnt !== (PERF ? m_flush : '0)) begin
        n_fail++;
        $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d",
          c, stall_cnt, flush_cnt,
          PERF ? m_stall : '0, PERF ? m_flush : '0);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect_lu();
    test_mem_freeze();
    test_halt_drain();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
